// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate L1 data cache.
// Serves a single-word CPU port and fills/writes through a single-word memory port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_responder #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_mbe,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_resp,
  output logic [31:0] cpu_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_mbe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam int KW = (OB > 0) ? OB : 1;

  typedef enum logic [1:0] {IDLE, RESP, FILL, WRITE} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            cpu_resp_q, cpu_resp_d;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [3:0]      mem_mbe_q, mem_mbe_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic [SETS-1:0] valid_q;
  logic [TB-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS][LINE_WORDS];

  logic [KW-1:0]   off;
  logic [IB-1:0]   idx;
  logic [TB-1:0]   tag;
  logic [31:0]     line_base;
  logic            hit;
  logic [31:0]     merged;
  logic            fill_we, wr_we, line_set;
  logic            unused_addr_bits;

  // Byte offset bits are never used; the port is word-granular.
  assign unused_addr_bits = ^cpu_addr[1:0];

  if (OB > 0) begin : g_off
    assign off = cpu_addr[2 +: OB];
  end else begin : g_off0
    assign off = '0;
  end

  assign idx       = cpu_addr[2+OB +: IB];
  assign tag       = cpu_addr[31 -: TB];
  assign line_base = {cpu_addr[31:2+OB], {(2+OB){1'b0}}};
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);

  // Write-hit data: old cached word with enabled bytes replaced.
  always_comb begin
    merged = data_q[idx][off];
    for (int b = 0; b < 4; b++)
      if (cpu_mbe[b]) merged[8*b +: 8] = cpu_wdata[8*b +: 8];
  end

  // Next-state and registered-output computation for the controller.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cpu_resp_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_mbe_d   = mem_mbe_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_we     = 1'b0;
    wr_we       = 1'b0;
    line_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_write) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = {cpu_addr[31:2], 2'b00};
          mem_wdata_d = cpu_wdata;
          mem_mbe_d   = cpu_mbe;
        end else if (cpu_read) begin
          if (hit) begin
            state_d     = RESP;
            cpu_resp_d  = 1'b1;
            cpu_rdata_d = data_q[idx][off];
          end else begin
            state_d    = FILL;
            k_d        = '0;
            mem_read_d = 1'b1;
            mem_addr_d = line_base;
            mem_mbe_d  = 4'hF;
          end
        end
      end
      FILL: begin
        mem_read_d = 1'b1;
        if (mem_resp) begin
          fill_we = 1'b1;
          if (k_q == KW'(LINE_WORDS - 1)) begin
            line_set    = 1'b1;
            state_d     = RESP;
            cpu_resp_d  = 1'b1;
            mem_read_d  = 1'b0;
            // Requested word may be the one arriving right now.
            cpu_rdata_d = (k_q == off) ? mem_rdata : data_q[idx][off];
          end else begin
            k_d        = k_q + KW'(1);
            mem_addr_d = line_base | (32'(k_d) << 2);
          end
        end
      end
      WRITE: begin
        mem_write_d = 1'b1;
        if (mem_resp) begin
          mem_write_d = 1'b0;
          wr_we       = hit;
          state_d     = RESP;
          cpu_resp_d  = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller state, registered outputs and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cpu_resp_q  <= 1'b0;
      cpu_rdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_mbe_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cpu_resp_q  <= cpu_resp_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_mbe_q   <= mem_mbe_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (line_set) valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays; validity is tracked separately so these need no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we)  data_q[idx][k_q] <= mem_rdata;
      if (wr_we)    data_q[idx][off] <= merged;
      if (line_set) tag_q[idx]       <= tag;
    end
  end

  assign cpu_resp  = cpu_resp_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_mbe   = mem_mbe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  // Count read lookups as they leave IDLE; writes are not counted.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && !cpu_write && cpu_read) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: random + directed bench for dcache_responder.
// Reference: backing-memory model (cache content always equals memory for a
// write-through cache) plus a per-set "resident line number" table.
module tb_dcache_responder;
  localparam int SETS = 16;
  localparam int LW   = 4;
  localparam int LSH  = $clog2(LW * 4);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [3:0]  cpu_mbe = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_resp;
  logic [31:0] cpu_rdata;
  logic        mem_read, mem_write;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_responder #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_mbe(cpu_mbe),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Backing memory: explicit entries, otherwise an address-derived pattern.
  logic [31:0] mem_model [int unsigned];
  function automatic logic [31:0] rd_mem(input int unsigned a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  int unsigned rd_log[$];
  int          wr_cnt = 0, both_cnt = 0, wait_cnt = 0;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_mbe;

  // Memory responder with random 0..2 cycle wait per transaction.
  initial begin
    logic [31:0] w;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both_cnt++;
      if (rst) begin
        mem_resp = 1'b0;
        wait_cnt = 0;
      end else if (mem_resp) begin
        mem_resp = 1'b0;
      end else if (mem_read || mem_write) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          if (mem_read) begin
            mem_rdata = rd_mem(mem_addr);
            rd_log.push_back(mem_addr);
          end else begin
            w = rd_mem(mem_addr);
            for (int b = 0; b < 4; b++)
              if (mem_mbe[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_model[mem_addr] = w;
            wr_cnt++;
            wr_addr = mem_addr; wr_data = mem_wdata; wr_mbe = mem_mbe;
          end
          mem_resp = 1'b1;
          wait_cnt = $urandom_range(0, 2);
        end
      end
    end
  end

  // Which line number occupies each set.
  bit          res_v    [SETS];
  int unsigned res_line [SETS];
  int          exp_hits = 0, exp_misses = 0;

  // One CPU transaction, checked against the model. Call on a negedge.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] mbe, output logic [31:0] rd);
    int unsigned wa, line;
    int          set, cyc;
    bit          exp_hit, got;
    logic [31:0] exp_d;
    wa      = a & ~32'd3;
    line    = wa >> LSH;
    set     = int'(line % SETS);
    exp_hit = res_v[set] && res_line[set] == line;
    exp_d   = rd_mem(wa);
    rd_log.delete();
    wr_cnt = 0; cyc = 0; got = 0;
    cpu_addr = a; cpu_wdata = wd; cpu_mbe = mbe;
    cpu_read = !wr; cpu_write = wr;
    while (cyc < 300 && !got) begin
      @(negedge clk);
      cyc++;
      if (cpu_resp) got = 1;
    end
    rd = cpu_rdata;
    cpu_read = 0; cpu_write = 0;
    chk("resp_seen", 32'(got), 1);
    if (!got) return;
    @(negedge clk);
    chk("resp_pulse", 32'(cpu_resp), 0);
    if (wr) begin
      chk("wr_count", wr_cnt, 1);
      chk("wr_noread", rd_log.size(), 0);
      chk("wr_addr", wr_addr, wa);
      chk("wr_data", wr_data, wd);
      chk("wr_mbe", 32'(wr_mbe), 32'(mbe));
    end else begin
      chk("rd_data", rd, exp_d);
      chk("rd_nowrite", wr_cnt, 0);
      if (exp_hit) begin
        exp_hits++;
        chk("hit_lat", cyc, 1);
        chk("hit_nomem", rd_log.size(), 0);
      end else begin
        exp_misses++;
        chk("fill_beats", rd_log.size(), LW);
        for (int i = 0; i < LW && i < rd_log.size(); i++)
          chk("fill_addr", rd_log[i], (line << LSH) + 4 * i);
        res_v[set]    = 1;
        res_line[set] = line;
      end
    end
  endtask

  initial begin
    logic [31:0] d, a;
    int          cyc;
    mem_model[32'h40] = 32'h11;
    mem_model[32'h44] = 32'h22;
    mem_model[32'h48] = 32'h33;
    mem_model[32'h4C] = 32'h44;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_cpu_resp", 32'(cpu_resp), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_mbe", 32'(mem_mbe), 0);

    // Directed plan.
    do_req(0, 32'h40, 0, 0, d);            chk("cold_rd", d, 32'h11);
    do_req(0, 32'h48, 0, 0, d);            chk("hit_rd", d, 32'h33);
    do_req(1, 32'h44, 32'hAABBCCDD, 4'b0011, d);
    do_req(0, 32'h44, 0, 0, d);            chk("merge_rd", d, 32'h0000CCDD);
    do_req(1, 32'h1000, 32'hCAFEF00D, 4'hF, d);
    do_req(0, 32'h1000, 0, 0, d);          chk("wmiss_fill", rd_log.size(), 4);
    do_req(0, 32'h440, 0, 0, d);           chk("conflict_fill", rd_log.size(), 4);
    do_req(0, 32'h40, 0, 0, d);            chk("conflict_refill", rd_log.size(), 4);

    // Random mix over a small footprint to force hits, misses and conflicts.
    for (int t = 0; t < 80; t++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 3)
        do_req(1, a, $urandom, 4'($urandom_range(0, 15)), d);
      else
        do_req(0, a, 0, 0, d);
    end

`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
`endif

    // Reset during the third fill beat.
    rd_log.delete();
    cpu_addr = 32'h2000; cpu_read = 1;
    cyc = 0;
    while (cyc < 300 && rd_log.size() < 2) begin
      @(negedge clk);
      cyc++;
    end
    chk("midfill_reach", 32'(rd_log.size() >= 2), 1);
    rst = 1; cpu_read = 0;
    @(negedge clk);
    rst = 0;
    chk("midfill_resp", 32'(cpu_resp), 0);
    chk("midfill_mread", 32'(mem_read), 0);
    @(negedge clk);
    chk("midfill_resp2", 32'(cpu_resp), 0);
    foreach (res_v[i]) res_v[i] = 0;
    exp_hits = 0; exp_misses = 0;
    do_req(0, 32'h2000, 0, 0, d);          chk("midfill_refill", rd_log.size(), 4);
    do_req(0, 32'h2004, 0, 0, d);

`ifdef DCACHE_STATS_EN
    chk("hit_count_rst", hit_count, exp_hits);
    chk("miss_count_rst", miss_count, exp_misses);
`endif
    chk("mem_rw_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Serves the pipeline's memory-stage data port (read/write/mbe/addr/wdata in, resp/rdata out) as the responder.
- Fills and writes through a single-word memory port.
- Sits between the datapath data port and the memory arbiter; the same block is usable on the instruction port with write tied low.

Parameters:
- SETS, 16, number of lines; power of 2, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_read  in  1  read request; held high until cpu_resp
- cpu_write  in  1  write request; held high until cpu_resp
- cpu_mbe  in  4  byte enables for writes
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  write data
- cpu_resp  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid when cpu_resp=1
- mem_read  out  1  memory word read, held until mem_resp
- mem_write  out  1  memory word write, held until mem_resp
- mem_mbe  out  4  byte enables to memory
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_resp  in  1  memory completion pulse
- mem_rdata  in  32  memory read data, valid with mem_resp

Behaviour:
- Address split: offset = addr[2+OB-1:2], OB = log2(LINE_WORDS). Index = next log2(SETS) bits. Tag = remaining upper bits.
- Storage: per line a valid bit, tag and LINE_WORDS data words. Hit = valid[index] && tag match.
- FSM states: IDLE, RESP, FILL, WRITE.
- IDLE:
  - Samples the request each cycle.
  - cpu_write (priority if both read and write are high) → WRITE.
  - cpu_read hit → RESP, with cpu_rdata latched from the array.
  - cpu_read miss → FILL, with fill counter k=0.
- FILL:
  - mem_read=1, mem_addr = {tag,index,k,2'b00}, mem_mbe=4'hF.
  - On mem_resp: word k is stored and k increments.
  - When mem_resp arrives with k=LINE_WORDS-1: valid and tag are set, cpu_rdata latches the requested word (from mem_rdata if k==offset, else from the array), and the FSM goes to RESP.
- WRITE:
  - mem_write=1, mem_addr={addr[31:2],2'b00}, mem_wdata=cpu_wdata, mem_mbe=cpu_mbe.
  - On mem_resp: if hit, bytes with mbe=1 are merged into the cached word. A miss leaves the cache untouched. The FSM goes to RESP.
- RESP: cpu_resp=1 for exactly one cycle, then IDLE.
- In IDLE the next request is sampled afresh, so back-to-back requests (same or different address) are legal. A request still high in the RESP cycle is not re-served.
- Latency:
  - Read hit: cpu_resp 1 cycle after request.
  - Read miss: LINE_WORDS memory transactions + 1 cycle.
  - Write: 1 memory transaction + 1 cycle.
- mem_read and mem_write are never high together. Both are low in IDLE and RESP. mem outputs stay stable while waiting on mem_resp.
- mem_resp arriving in IDLE or RESP is ignored.
- Reset values: cpu_resp=0, cpu_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_mbe=0. All valid bits are cleared and the state is IDLE.
- Reset mid-FILL or mid-WRITE: the line stays invalid, the memory transaction is abandoned, and no cpu_resp is issued.
- cpu_addr, cpu_wdata and cpu_mbe are required stable while the request is high. They are not registered.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - Each read-hit and each read-miss increments its counter once, on the IDLE→RESP or IDLE→FILL transition.
  - Counters wrap at 2^32; writes are not counted.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Cold read 0x0000_0040, memory returns 0x11,0x22,0x33,0x44 for 0x40..0x4C → four mem_read addrs 0x40,0x44,0x48,0x4C in order; cpu_resp once; cpu_rdata=0x11.
- Read 0x48 immediately after → no mem activity; cpu_resp 1 cycle after request; cpu_rdata=0x33.
- Write 0x44, wdata=0xAABBCCDD, mbe=4'b0011 → mem_write with mem_mbe=0011, mem_addr=0x44; then read 0x44 hits returning 0x0000CCDD (old word 0x22).
- Write miss 0x1000 then read 0x1000 → write passes through with no fill; the read misses and fills 0x1000..0x100C.
- Conflict: read 0x40 then 0x440 (same index, SETS=16, LINE_WORDS=4) → second read refills; re-read 0x40 misses again.
- rst asserted during the third FILL beat → no cpu_resp; mem_read=0 next cycle; re-read of the same address refills all four words.
